// File: rtl/mandelbrot_pkg.sv
// Shared defaults and FSM encoding for the mandelbrot coordinate feeder.
// Imported by the coordinate generator and its per-axis accumulator.
package mandelbrot_pkg;

    localparam int FPW_DEF  = 54;
    localparam int AW_DEF   = 11;
    localparam int HRES_DEF = 800;
    localparam int VRES_DEF = 600;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } gen_state_t;

endpackage

// File: rtl/mandelbrot_axis_step.sv
// Generic fixed-point accumulator: load a value, add an increment, or hold.
// One instance per axis; wraps modulo 2**FPW.
module mandelbrot_axis_step
    import mandelbrot_pkg::*;
#(
    parameter int FPW = FPW_DEF
) (
    input  logic           clk,
    input  logic           clk_en,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [FPW-1:0] load_val,
    input  logic [FPW-1:0] inc,
    output logic [FPW-1:0] acc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clk_en) begin
            if (load) begin
                acc <= load_val;
            end else if (step) begin
                acc <= acc + inc;
            end
        end
    end

endmodule

// File: rtl/mandelbrot_coord_gen.sv
// Walks an HRES x VRES frame row-major, emitting one fixed-point (x, y)
// coordinate and line-buffer address per pixel on a valid/ready stream.
module mandelbrot_coord_gen
    import mandelbrot_pkg::*;
#(
    parameter int FPW  = FPW_DEF,
    parameter int AW   = AW_DEF,
    parameter int HRES = HRES_DEF,
    parameter int VRES = VRES_DEF
) (
    input  logic           clk,
    input  logic           clk_en,
    input  logic           rst,
    input  logic           start,
    input  logic [FPW-1:0] x0,
    input  logic [FPW-1:0] y0,
    input  logic [FPW-1:0] dx,
    input  logic [FPW-1:0] dy,
    output logic           busy,
    output logic           done,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [FPW-1:0] x_man,
    output logic [FPW-1:0] y_man,
    output logic [AW-1:0]  adr_o,
    output logic           line_last,
    output logic           frame_last
);

    localparam int CW = (HRES > 1) ? $clog2(HRES) : 1;
    localparam int RW = (VRES > 1) ? $clog2(VRES) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(HRES - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(VRES - 1);
    localparam logic ONE_COL = (COL_MAX == '0);
    localparam logic ONE_ROW = (ROW_MAX == '0);

    gen_state_t     state;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [FPW-1:0] x0_q;
    logic [FPW-1:0] dx_q;
    logic [FPW-1:0] dy_q;

    logic xfer;
    logic at_eol;
    logic at_eof;
    logic start_ok;
    logic x_load;
    logic x_step;
    logic y_load;
    logic y_step;
    logic [FPW-1:0] x_val;

    assign xfer     = out_vld & out_rdy;
    assign at_eol   = (col == COL_MAX);
    assign at_eof   = at_eol & (row == ROW_MAX);
    assign start_ok = (state == IDLE) & start;

    // Row wrap reloads x from the latched origin, not the live input.
    assign x_load = start_ok | (xfer & at_eol & ~at_eof);
    assign x_val  = start_ok ? x0 : x0_q;
    assign x_step = xfer & ~at_eol;
    assign y_load = start_ok;
    assign y_step = xfer & at_eol & ~at_eof;

    assign adr_o = AW'(col);

    mandelbrot_axis_step #(.FPW(FPW)) u_x_axis (
        .clk      (clk),
        .clk_en   (clk_en),
        .rst      (rst),
        .load     (x_load),
        .step     (x_step),
        .load_val (x_val),
        .inc      (dx_q),
        .acc      (x_man)
    );

    mandelbrot_axis_step #(.FPW(FPW)) u_y_axis (
        .clk      (clk),
        .clk_en   (clk_en),
        .rst      (rst),
        .load     (y_load),
        .step     (y_step),
        .load_val (y0),
        .inc      (dy_q),
        .acc      (y_man)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_vld    <= 1'b0;
            line_last  <= 1'b0;
            frame_last <= 1'b0;
            col        <= '0;
            row        <= '0;
            x0_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
        end else if (clk_en) begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x0_q       <= x0;
                        dx_q       <= dx;
                        dy_q       <= dy;
                        col        <= '0;
                        row        <= '0;
                        out_vld    <= 1'b1;
                        busy       <= 1'b1;
                        line_last  <= ONE_COL;
                        frame_last <= ONE_COL & ONE_ROW;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (at_eof) begin
                            out_vld    <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            line_last  <= 1'b0;
                            frame_last <= 1'b0;
                            col        <= '0;
                            row        <= '0;
                            state      <= DONE;
                        end else if (at_eol) begin
                            col        <= '0;
                            row        <= row + RW'(1);
                            line_last  <= ONE_COL;
                            frame_last <= ONE_COL
                                & (row + RW'(1) == ROW_MAX);
                        end else begin
                            col        <= col + CW'(1);
                            line_last  <= (col + CW'(1) == COL_MAX);
                            frame_last <= (col + CW'(1) == COL_MAX)
                                & (row == ROW_MAX);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_coord_gen.sv
// Scoreboard bench for mandelbrot_coord_gen on a 4x3 frame, 16-bit coords.
// Driver pushes expected pixels; a negedge monitor pops and compares.
module tb_mandelbrot_coord_gen;

    localparam int FPW  = 16;
    localparam int AW   = 4;
    localparam int HRES = 4;
    localparam int VRES = 3;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  adr;
        logic        ll;
        logic        fl;
    } exp_t;

    logic           clk;
    logic           clk_en;
    logic           rst;
    logic           start;
    logic [FPW-1:0] x0;
    logic [FPW-1:0] y0;
    logic [FPW-1:0] dx;
    logic [FPW-1:0] dy;
    logic           busy;
    logic           done;
    logic           out_vld;
    logic           out_rdy;
    logic [FPW-1:0] x_man;
    logic [FPW-1:0] y_man;
    logic [AW-1:0]  adr_o;
    logic           line_last;
    logic           frame_last;

    exp_t q[$];
    int   n_pass;
    int   n_total;
    int   pops;
    int   frames_done;
    int   done_seen;
    bit   mon_en;
    bit   exp_done;

    mandelbrot_coord_gen #(
        .FPW  (FPW),
        .AW   (AW),
        .HRES (HRES),
        .VRES (VRES)
    ) dut (
        .clk        (clk),
        .clk_en     (clk_en),
        .rst        (rst),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .dx         (dx),
        .dy         (dy),
        .busy       (busy),
        .done       (done),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .x_man      (x_man),
        .y_man      (y_man),
        .adr_o      (adr_o),
        .line_last  (line_last),
        .frame_last (frame_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_total++;
        $display("FAIL %s: got timeout want completion", nm);
    endtask

    task automatic push_frame(input logic [15:0] ax0, input logic [15:0] ay0,
                              input logic [15:0] adx, input logic [15:0] ady);
        exp_t e;
        for (int r = 0; r < VRES; r++) begin
            for (int c = 0; c < HRES; c++) begin
                e.x   = 16'(ax0 + 16'(c) * adx);
                e.y   = 16'(ay0 + 16'(r) * ady);
                e.adr = 4'(c);
                e.ll  = (c == HRES - 1);
                e.fl  = (c == HRES - 1) && (r == VRES - 1);
                q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (clk_en && done) done_seen++;
        if (mon_en) begin
            if (exp_done) begin
                check("done_pulse", {31'd0, done}, 32'd1);
                check("busy_at_done", {31'd0, busy}, 32'd0);
                check("vld_at_done", {31'd0, out_vld}, 32'd0);
                exp_done = 1'b0;
                frames_done++;
            end else if (out_vld) begin
                if (q.size() == 0) begin
                    check("unexpected_vld", {31'd0, out_vld}, 32'd0);
                end else begin
                    check("x_man", {16'd0, x_man}, {16'd0, q[0].x});
                    check("y_man", {16'd0, y_man}, {16'd0, q[0].y});
                    check("adr_o", {28'd0, adr_o}, {28'd0, q[0].adr});
                    check("line_last", {31'd0, line_last},
                          {31'd0, q[0].ll});
                    check("frame_last", {31'd0, frame_last},
                          {31'd0, q[0].fl});
                    if (clk_en && out_rdy) begin
                        if (q[0].fl) exp_done = 1'b1;
                        void'(q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    task automatic run_frame(input logic [15:0] ax0, input logic [15:0] ay0,
                             input logic [15:0] adx, input logic [15:0] ady,
                             input int mode, input int pause_at,
                             input int rst_at);
        int  base;
        int  fd0;
        int  ds0;
        int  held;
        int  cyc;
        bit  paused;
        base = pops;
        fd0  = frames_done;
        push_frame(ax0, ay0, adx, ady);
        x0 = ax0;
        y0 = ay0;
        dx = adx;
        dy = ady;
        start = 1'b1;
        out_rdy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x0 = 16'hDEAD;
        y0 = 16'hBEEF;
        dx = 16'h1111;
        dy = 16'h2222;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        paused = 1'b0;
        for (cyc = 0; cyc < 400 && frames_done == fd0; cyc++) begin
            if (rst_at > 0 && pops - base >= rst_at) begin
                ds0 = done_seen;
                rst = 1'b1;
                out_rdy = 1'b0;
                mon_en = 1'b0;
                q.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_vld", {31'd0, out_vld}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_adr", {28'd0, adr_o}, 32'd0);
                check("rst_x", {16'd0, x_man}, 32'd0);
                repeat (4) begin
                    @(posedge clk); #1;
                end
                mon_en = 1'b1;
                check("no_done_after_rst", done_seen, ds0);
                return;
            end
            if (pause_at > 0 && !paused && pops - base >= pause_at) begin
                held = pops;
                out_rdy = 1'b1;
                clk_en = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                end
                check("pause_no_xfer", pops, held);
                check("pause_busy", {31'd0, busy}, 32'd1);
                clk_en = 1'b1;
                paused = 1'b1;
            end
            if (mode == 1) out_rdy = 1'($urandom_range(0, 1));
            else out_rdy = 1'b1;
            if (mode == 1 && cyc == 4) begin
                start = 1'b1;
                x0 = 16'h1234;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (mode == 1 && cyc == 4)
                check("busy_ignore_start", {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
        if (frames_done == fd0) begin
            fail("frame_timeout");
        end else begin
            check("done_cleared", {31'd0, done}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("frame_pixels", pops - base, HRES * VRES);
            check("queue_empty", q.size(), 0);
        end
        out_rdy = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        pops = 0;
        frames_done = 0;
        done_seen = 0;
        exp_done = 1'b0;
        mon_en = 1'b0;
        clk_en = 1'b1;
        rst = 1'b1;
        start = 1'b0;
        out_rdy = 1'b0;
        x0 = '0;
        y0 = '0;
        dx = '0;
        dy = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_vld", {31'd0, out_vld}, 32'd0);
        check("reset_x", {16'd0, x_man}, 32'd0);
        check("reset_y", {16'd0, y_man}, 32'd0);
        check("reset_adr", {28'd0, adr_o}, 32'd0);
        check("reset_flags", {30'd0, line_last, frame_last}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        run_frame(16'hFF00, 16'h0100, 16'h0040, 16'hFFC0, 0, 0, 0);
        run_frame(16'hFF00, 16'h0100, 16'h0040, 16'hFFC0, 1, 0, 0);
        run_frame(16'hFF00, 16'h0100, 16'h0040, 16'hFFC0, 0, 5, 0);
        run_frame(16'h0200, 16'h0300, 16'h0010, 16'h0020, 0, 0, 6);
        run_frame(16'h0200, 16'h0300, 16'h0010, 16'h0020, 0, 0, 0);
        run_frame(16'h7FC0, 16'h0000, 16'h0040, 16'h0010, 0, 0, 0);
        run_frame(16'h7FC0, 16'h8000, 16'h0040, 16'hFFF0, 1, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mandelbrot_coord_gen.md
Name: mandelbrot_coord_gen

Overview:
Upstream feeder of the mandelbrot calculation wrapper. On a start pulse it latches a view window (origin, per-pixel steps) and walks the HRES x VRES frame row-major. For each pixel it emits one fixed-point (x, y) coordinate plus a line-buffer address on a valid/ready stream. Stream data maps directly onto the calc wrapper's x_man/y_man/adr_i inputs.

Parameters:
FPW, 54, bitwidth of two's-complement fixed-point coordinates and steps
AW, 11, address width; must satisfy HRES <= 2**AW
HRES, 800, pixels per row
VRES, 600, rows per frame

Ports:
clk  in  1  clock
clk_en  in  1  clock enable; all state advances only when high
rst  in  1  synchronous active-high reset
start  in  1  frame start request (sampled when clk_en=1)
x0  in  FPW  left-column x coordinate, latched on accepted start
y0  in  FPW  top-row y coordinate, latched on accepted start
dx  in  FPW  x step per column, latched on accepted start
dy  in  FPW  y step per row, signed, latched on accepted start
busy  out  1  high from accepted start until the last pixel transfers
done  out  1  one-cycle pulse after the last pixel transfers
out_vld  out  1  coordinate valid
out_rdy  in  1  downstream ready
x_man  out  FPW  pixel x coordinate
y_man  out  FPW  pixel y coordinate
adr_o  out  AW  column index of the pixel (line-buffer address)
line_last  out  1  high with the last pixel of each row
frame_last  out  1  high with the last pixel of the frame

Behaviour:
- Reset (rst=1 at a clk edge, regardless of clk_en): state IDLE. busy=0, done=0, out_vld=0, x_man=0, y_man=0, adr_o=0, line_last=0, frame_last=0, and col/row counters =0. Reset mid-frame abandons the frame; no done pulse.
- A cycle is "active" when clk_en=1. Transfer = active & out_vld & out_rdy. With clk_en=0 every register holds and no transfer occurs.
- FSM IDLE: an active cycle with start=1 latches x0/y0/dx/dy, loads x_man=x0, y_man=y0, col=row=0, adr_o=0, and sets out_vld=1 and busy=1. Next state is RUN. Latency is one active cycle from start to first out_vld.
- FSM RUN: out_vld stays 1. x_man, y_man, adr_o and the flags are stable until a transfer occurs.
- On transfer, when not at the end of a row: col+1, adr_o=col+1, x_man=x_man+dx.
- On transfer at the end of a row (col=HRES-1) but not the last row: col=0, adr_o=0, x_man=x0 (latched), row+1, y_man=y_man+dy.
- On transfer at the last pixel (col=HRES-1, row=VRES-1): out_vld=0, busy=0, done=1 for exactly one active cycle. State goes through DONE and then returns to IDLE.
- line_last = (col==HRES-1). frame_last = line_last & (row==VRES-1). Both are registered, combinational only from the counters, and valid only while out_vld=1.
- start while busy or in DONE: ignored. start in the same active cycle as the done pulse: ignored. A new frame may start from the following IDLE cycle.
- done is cleared on the next active cycle. With clk_en=0 it stays high (held).
- Arithmetic: FPW-bit two's-complement add, wrapping modulo 2**FPW, no saturation. Coordinates are produced by accumulation, not multiplication. Counter widths are $clog2(HRES) and $clog2(VRES). adr_o is the zero-extended col.
- Throughput: one pixel per active cycle while out_rdy=1. A frame takes HRES*VRES transfers.
- Inputs x0/y0/dx/dy changing while busy have no effect.

Decomposition:
- Shared package mandelbrot_pkg holds the FPW and AW defaults, the HRES/VRES defaults, and the FSM state encoding (IDLE, RUN, DONE) as localparams.
- One natural sub-module, mandelbrot_axis_step. It is a generic FPW-bit accumulator with load(value), step(inc) and hold, instantiated twice (x axis and y axis). Counters and the FSM stay in the top module.

Test Plan:
1. Bench override HRES=4, VRES=3, FPW=16. Stimulus: start with x0=0xFF00, dx=0x0040, y0=0x0100, dy=0xFFC0, out_rdy=1. Required: 12 transfers with x = FF00, FF40, FF80, FFC0 repeating per row and y = 0100, 00C0, 0080. adr_o cycles 0..3. line_last is high on transfers 4, 8, 12; frame_last only on 12. done pulses one cycle after transfer 12.
2. Backpressure: toggle out_rdy pseudo-randomly. Required: identical 12-value sequence, data stable while out_vld=1 and out_rdy=0, no drops or duplicates.
3. clk_en held low for 5 cycles mid-frame with out_rdy=1. Required: all outputs frozen, no transfers; the sequence resumes exactly where it stopped.
4. start pulsed during RUN with different x0. Required: ignored, current frame unchanged, busy stays 1.
5. rst asserted at pixel 6. Required: next cycle out_vld=0, busy=0, done never pulses. A new start restarts at x0,y0 with adr_o=0.
6. Wrap: x0=0x7FC0, dx=0x0040. Required: second pixel x=0x8000 (modulo wrap), no saturation.
